// File: rtl/bm_buf_release_mc_if.sv
// Handshake and bus bundle for the buffer release manager: counter init/set
// inputs, per-channel release requests, the buffer-free output stream,
// the release counter and the sticky error flags.
interface bm_buf_release_mc_if #(
    parameter int BUF_PTR_NBITS    = 10,
    parameter int PORT_ID_NBITS    = 4,
    parameter int READ_COUNT_NBITS = 4,
    parameter int NUM_REL          = 2
);
    logic                                init_valid;
    logic [BUF_PTR_NBITS-1:0]            init_ptr;
    logic                                set_valid;
    logic [PORT_ID_NBITS-1:0]            set_port_id;
    logic [BUF_PTR_NBITS-1:0]            set_buf_ptr;
    logic [READ_COUNT_NBITS-1:0]         set_count;
    logic [NUM_REL-1:0]                  rel_valid;
    logic [NUM_REL-1:0]                  rel_ready;
    logic [NUM_REL*PORT_ID_NBITS-1:0]    rel_port_id;
    logic [NUM_REL*BUF_PTR_NBITS-1:0]    rel_ptr;
    logic                                out_valid;
    logic                                out_ready;
    logic [PORT_ID_NBITS-1:0]            out_port_id;
    logic [BUF_PTR_NBITS-1:0]            out_ptr;
    logic [31:0]                         release_cnt;
    logic                                err_underflow;
    logic                                err_overflow;
    logic                                err_collision;

    modport master (
        output init_valid, init_ptr, set_valid, set_port_id, set_buf_ptr, set_count,
        output rel_valid, rel_port_id, rel_ptr, out_ready,
        input  rel_ready, out_valid, out_port_id, out_ptr, release_cnt,
        input  err_underflow, err_overflow, err_collision
    );

    modport slave (
        input  init_valid, init_ptr, set_valid, set_port_id, set_buf_ptr, set_count,
        input  rel_valid, rel_port_id, rel_ptr, out_ready,
        output rel_ready, out_valid, out_port_id, out_ptr, release_cnt,
        output err_underflow, err_overflow, err_collision
    );
endinterface

// File: rtl/bm_buf_release_mc.sv
// Multicast buffer release manager. Each buffer carries a remaining-read
// count; release requests from NUM_REL channels are round-robin arbitrated
// and decrement it, and the buffer is handed to the free list through a
// small output queue when its last read completes.
module bm_buf_release_mc #(
    parameter int BUF_PTR_NBITS    = 10,
    parameter int PORT_ID_NBITS    = 4,
    parameter int READ_COUNT_NBITS = 4,
    parameter int NUM_REL          = 2,
    parameter int OQ_DEPTH         = 4
) (
    input  logic              clk,
    input  logic              rst,
    bm_buf_release_mc_if.slave bm
);
    localparam int TBL_DEPTH = 1 << BUF_PTR_NBITS;
    localparam int QAW       = $clog2(OQ_DEPTH);
    localparam int RRW       = (NUM_REL > 1) ? $clog2(NUM_REL) : 1;
    localparam int EW        = PORT_ID_NBITS + BUF_PTR_NBITS;

    localparam logic [RRW:0]                NREL          = (RRW+1)'(NUM_REL);
    localparam logic [RRW-1:0]              LAST_CH       = RRW'(NUM_REL - 1);
    localparam logic [QAW:0]                OQ_FULL       = (QAW+1)'(OQ_DEPTH);
    localparam logic [QAW:0]                GRANT_MAX_OCC = (QAW+1)'(OQ_DEPTH - 2);
    localparam logic [READ_COUNT_NBITS-1:0] CNT_ONE       = READ_COUNT_NBITS'(1);

    logic [READ_COUNT_NBITS-1:0] remaining_q [TBL_DEPTH];
    logic [EW-1:0]               oq_mem_q [OQ_DEPTH];
    logic [QAW-1:0]              oq_wr_q, oq_rd_q;
    logic [QAW:0]                oq_cnt_q, oq_cnt_d;
    logic [RRW-1:0]              rr_q, rr_d;
    logic [31:0]                 release_cnt_q;
    logic                        err_underflow_q, err_overflow_q, err_collision_q;

    logic                        grant_ok, gnt_found, grant;
    logic [RRW:0]                idx_sum;
    logic [RRW-1:0]              idx_sel, gnt_idx;
    logic [NUM_REL-1:0]          gnt_vec;
    logic [BUF_PTR_NBITS-1:0]    rel_ptr_sel;
    logic [PORT_ID_NBITS-1:0]    rel_port_sel;
    logic [READ_COUNT_NBITS-1:0] rel_cur;
    logic                        set_eff, set_write, set_push, set_drop;
    logic                        rel_dec, rel_last, rel_under;
    logic [EW-1:0]               push_e0, push_e1;
    logic [1:0]                  n_push;
    logic                        pop, out_valid;

    // Round-robin search from rr_q; a grant also needs two free queue slots
    // so that a simultaneous set push and release push always fit.
    always_comb begin
        grant_ok  = !rst && !bm.init_valid && (oq_cnt_q <= GRANT_MAX_OCC);
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_sum   = '0;
        idx_sel   = '0;
        gnt_vec   = '0;
        for (int k = 0; k < NUM_REL; k++) begin
            idx_sum = {1'b0, rr_q} + (RRW+1)'(k);
            if (idx_sum >= NREL) idx_sum = idx_sum - NREL;
            idx_sel = idx_sum[RRW-1:0];
            if (!gnt_found && bm.rel_valid[idx_sel]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_sel;
            end
        end
        grant = grant_ok && gnt_found;
        if (grant) gnt_vec[gnt_idx] = 1'b1;
        rr_d = rr_q;
        if (grant) rr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end

    // Counter update: a same-cycle set on the released pointer is applied
    // first, so the release operates on the freshly set count.
    always_comb begin
        rel_ptr_sel  = bm.rel_ptr[int'(gnt_idx)*BUF_PTR_NBITS +: BUF_PTR_NBITS];
        rel_port_sel = bm.rel_port_id[int'(gnt_idx)*PORT_ID_NBITS +: PORT_ID_NBITS];
        set_eff      = bm.set_valid && !bm.init_valid && !rst;
        set_write    = set_eff && (bm.set_count != '0);
        set_push     = set_eff && (bm.set_count == '0) && (oq_cnt_q != OQ_FULL);
        set_drop     = set_eff && (bm.set_count == '0) && (oq_cnt_q == OQ_FULL);
        rel_cur      = (set_eff && (bm.set_buf_ptr == rel_ptr_sel)) ? bm.set_count
                                                                   : remaining_q[rel_ptr_sel];
        rel_dec      = grant && (rel_cur > CNT_ONE);
        rel_last     = grant && (rel_cur == CNT_ONE);
        rel_under    = grant && (rel_cur == '0);
    end

    // Queue push/pop bookkeeping; the set entry always takes the first slot.
    always_comb begin
        push_e0  = set_push ? {bm.set_port_id, bm.set_buf_ptr} : {rel_port_sel, rel_ptr_sel};
        push_e1  = {rel_port_sel, rel_ptr_sel};
        n_push   = {1'b0, set_push} + {1'b0, rel_last};
        out_valid = (oq_cnt_q != '0) && !rst;
        pop      = out_valid && bm.out_ready;
        oq_cnt_d = oq_cnt_q + (QAW+1)'(n_push) - (QAW+1)'(pop);
    end

    // Counter table, deliberately not reset; software clears entries with init.
    always_ff @(posedge clk) begin
        if (bm.init_valid) begin
            remaining_q[bm.init_ptr] <= '0;
        end else begin
            if (set_write) remaining_q[bm.set_buf_ptr] <= bm.set_count;
            if (rel_dec || rel_last) remaining_q[rel_ptr_sel] <= rel_dec ? rel_cur - CNT_ONE : '0;
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) oq_mem_q[oq_wr_q] <= push_e0;
        if (n_push == 2'd2) oq_mem_q[oq_wr_q + 1'b1] <= push_e1;
    end

    // Queue pointers, arbiter pointer, release counter and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            oq_wr_q         <= '0;
            oq_rd_q         <= '0;
            oq_cnt_q        <= '0;
            rr_q            <= '0;
            release_cnt_q   <= '0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_collision_q <= 1'b0;
        end else begin
            oq_wr_q         <= oq_wr_q + QAW'(n_push);
            if (pop) oq_rd_q <= oq_rd_q + 1'b1;
            oq_cnt_q        <= oq_cnt_d;
            rr_q            <= rr_d;
            if (pop) release_cnt_q <= release_cnt_q + 32'd1;
            err_underflow_q <= err_underflow_q | rel_under;
            err_overflow_q  <= err_overflow_q | set_drop;
            err_collision_q <= err_collision_q | (bm.init_valid & bm.set_valid);
        end
    end

    assign bm.rel_ready                 = gnt_vec;
    assign bm.out_valid                 = out_valid;
    assign {bm.out_port_id, bm.out_ptr} = oq_mem_q[oq_rd_q];
    assign bm.release_cnt               = release_cnt_q;
    assign bm.err_underflow             = err_underflow_q;
    assign bm.err_overflow              = err_overflow_q;
    assign bm.err_collision             = err_collision_q;
endmodule

// File: tb/tb_bm_buf_release_mc.sv
// Bench for bm_buf_release_mc: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_bm_buf_release_mc;
    localparam int BP = 10, PI = 4, RC = 4, NR = 4, OQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bm_buf_release_mc_if #(.BUF_PTR_NBITS(BP), .PORT_ID_NBITS(PI),
                           .READ_COUNT_NBITS(RC), .NUM_REL(NR)) bif ();

    bm_buf_release_mc #(.BUF_PTR_NBITS(BP), .PORT_ID_NBITS(PI), .READ_COUNT_NBITS(RC),
                        .NUM_REL(NR), .OQ_DEPTH(OQ)) dut (.clk(clk), .rst(rst), .bm(bif));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int port; int ptr; } ent_t;

    task automatic idle();
        bif.init_valid = 1'b0; bif.init_ptr = '0;
        bif.set_valid = 1'b0; bif.set_port_id = '0; bif.set_buf_ptr = '0; bif.set_count = '0;
        bif.rel_valid = '0; bif.rel_port_id = '0; bif.rel_ptr = '0;
        bif.out_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    endtask

    task automatic do_init(input int ptr);
        bif.init_valid = 1'b1; bif.init_ptr = BP'(ptr); tick(); bif.init_valid = 1'b0;
    endtask

    task automatic do_set(input int port, input int ptr, input int n);
        bif.set_valid = 1'b1; bif.set_port_id = PI'(port); bif.set_buf_ptr = BP'(ptr);
        bif.set_count = RC'(n); tick(); bif.set_valid = 1'b0;
    endtask

    task automatic set_rel(input int ch, input int port, input int ptr);
        bif.rel_valid[ch] = 1'b1;
        bif.rel_port_id[ch*PI +: PI] = PI'(port);
        bif.rel_ptr[ch*BP +: BP] = BP'(ptr);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        for (int c = 0; c < NR; c++) set_rel(c, c, c);
        #1;
        n_tests++; if (bif.rel_ready !== '0) begin n_fail++; $display("FAIL rst_rel_ready got %b want 0", bif.rel_ready); end
        tick(); tick();
        n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bif.out_valid); end
        n_tests++; if (bif.release_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_release_cnt got %0d want 0", bif.release_cnt); end
        n_tests++; if ({bif.err_underflow, bif.err_overflow, bif.err_collision} !== 3'b000) begin
            n_fail++; $display("FAIL rst_errs got %b want 000", {bif.err_underflow, bif.err_overflow, bif.err_collision}); end
        idle(); rst = 1'b0;
    endtask

    task automatic test_count3();
        do_reset(); do_init(5); do_set(1, 5, 3); bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rel(0, 1, 5); #1;
            n_tests++; if (bif.rel_ready !== 4'b0001) begin n_fail++; $display("FAIL cnt3_ready[%0d] got %b want 0001", i, bif.rel_ready); end
            tick(); bif.rel_valid = '0;
            n_tests++; if (bif.out_valid !== (i == 2)) begin n_fail++; $display("FAIL cnt3_valid[%0d] got %b want %0d", i, bif.out_valid, i == 2); end
        end
        n_tests++; if (bif.out_ptr !== 10'd5 || bif.out_port_id !== 4'd1) begin
            n_fail++; $display("FAIL cnt3_entry got ptr %0d port %0d want ptr 5 port 1", bif.out_ptr, bif.out_port_id); end
        tick();
        n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL cnt3_drained got %b want 0", bif.out_valid); end
        n_tests++; if (bif.release_cnt !== 32'd1) begin n_fail++; $display("FAIL cnt3_release_cnt got %0d want 1", bif.release_cnt); end
    endtask

    task automatic test_set_zero();
        do_reset(); do_init(9); do_set(0, 9, 2); do_set(2, 9, 0);
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_port_id !== 4'd2 || bif.out_ptr !== 10'd9) begin
            n_fail++; $display("FAIL setz_entry got v%b port %0d ptr %0d want v1 port 2 ptr 9", bif.out_valid, bif.out_port_id, bif.out_ptr); end
        bif.out_ready = 1'b1; tick();
        n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL setz_pop got %b want 0", bif.out_valid); end
        set_rel(1, 3, 9); tick(); bif.rel_valid = '0;
        n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL setz_first_rel got %b want 0", bif.out_valid); end
        set_rel(1, 3, 9); tick(); bif.rel_valid = '0;
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_port_id !== 4'd3 || bif.out_ptr !== 10'd9) begin
            n_fail++; $display("FAIL setz_table_kept got v%b port %0d ptr %0d want v1 port 3 ptr 9", bif.out_valid, bif.out_port_id, bif.out_ptr); end
        n_tests++; if (bif.err_underflow !== 1'b0) begin n_fail++; $display("FAIL setz_no_underflow got %b want 0", bif.err_underflow); end
    endtask

    task automatic test_rr();
        logic [NR-1:0] exp_v;
        do_reset();
        for (int k = 0; k < NR; k++) begin do_init(20 + k); do_set(0, 20 + k, 1); end
        bif.out_ready = 1'b1;
        for (int k = 0; k < NR; k++) set_rel(k, k, 20 + k);
        for (int k = 0; k < NR; k++) begin
            #1; exp_v = '0; exp_v[k] = 1'b1;
            n_tests++; if (bif.rel_ready !== exp_v) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", k, bif.rel_ready, exp_v); end
            tick();
            n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== BP'(20 + k) || bif.out_port_id !== PI'(k)) begin
                n_fail++; $display("FAIL rr_out[%0d] got v%b ptr %0d port %0d want ptr %0d port %0d", k, bif.out_valid, bif.out_ptr, bif.out_port_id, 20 + k, k); end
        end
        bif.rel_valid = '0; tick();
        n_tests++; if (bif.release_cnt !== 32'd4 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_done got cnt %0d v%b want cnt 4 v0", bif.release_cnt, bif.out_valid); end
    endtask

    task automatic test_backpressure();
        int exp_ptr [4] = '{30, 31, 32, 40};
        do_reset();
        for (int k = 0; k < 3; k++) begin do_init(30 + k); do_set(0, 30 + k, 1); end
        for (int k = 0; k < 3; k++) begin
            set_rel(0, 7, 30 + k); #1;
            n_tests++; if (bif.rel_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_fill_ready[%0d] got %b want 0001", k, bif.rel_ready); end
            tick(); bif.rel_valid = '0;
        end
        set_rel(0, 7, 30); #1;
        n_tests++; if (bif.rel_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_blocked got %b want 0000", bif.rel_ready); end
        tick();
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== 10'd30) begin
            n_fail++; $display("FAIL bp_stable got v%b ptr %0d want v1 ptr 30", bif.out_valid, bif.out_ptr); end
        bif.rel_valid = '0;
        do_set(5, 40, 0);
        n_tests++; if (bif.err_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_last_slot got %b want 0", bif.err_overflow); end
        do_set(5, 41, 0);
        n_tests++; if (bif.err_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", bif.err_overflow); end
        bif.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== BP'(exp_ptr[k])) begin
                n_fail++; $display("FAIL bp_drain[%0d] got v%b ptr %0d want ptr %0d", k, bif.out_valid, bif.out_ptr, exp_ptr[k]); end
            tick();
        end
        n_tests++; if (bif.out_valid !== 1'b0 || bif.release_cnt !== 32'd4) begin
            n_fail++; $display("FAIL bp_empty got v%b cnt %0d want v0 cnt 4", bif.out_valid, bif.release_cnt); end
    endtask

    task automatic test_underflow();
        do_reset(); do_init(11); set_rel(0, 0, 11); tick(); bif.rel_valid = '0;
        n_tests++; if (bif.out_valid !== 1'b0 || bif.err_underflow !== 1'b1) begin
            n_fail++; $display("FAIL uf_flag got v%b uf%b want v0 uf1", bif.out_valid, bif.err_underflow); end
        tick(); tick(); tick();
        n_tests++; if (bif.err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", bif.err_underflow); end
        do_reset();
        n_tests++; if (bif.err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_cleared got %b want 0", bif.err_underflow); end
    endtask

    task automatic test_same_cycle();
        do_reset(); do_init(7);
        bif.set_valid = 1'b1; bif.set_port_id = 4'd4; bif.set_buf_ptr = 10'd7; bif.set_count = 4'd1;
        set_rel(0, 6, 7); #1;
        n_tests++; if (bif.rel_ready !== 4'b0001) begin n_fail++; $display("FAIL sc_ready got %b want 0001", bif.rel_ready); end
        tick(); idle();
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== 10'd7 || bif.out_port_id !== 4'd6) begin
            n_fail++; $display("FAIL sc_out got v%b ptr %0d port %0d want v1 ptr 7 port 6", bif.out_valid, bif.out_ptr, bif.out_port_id); end
        bif.out_ready = 1'b1; tick();
        set_rel(0, 6, 7); tick(); bif.rel_valid = '0;
        n_tests++; if (bif.err_underflow !== 1'b1 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL sc_zeroed got uf%b v%b want uf1 v0", bif.err_underflow, bif.out_valid); end
        do_reset(); do_init(8); do_set(0, 8, 1);
        bif.set_valid = 1'b1; bif.set_port_id = 4'd2; bif.set_buf_ptr = 10'd12; bif.set_count = 4'd0;
        set_rel(2, 9, 8); tick(); idle();
        n_tests++; if (bif.out_ptr !== 10'd12 || bif.out_port_id !== 4'd2) begin
            n_fail++; $display("FAIL sc_order0 got ptr %0d port %0d want ptr 12 port 2", bif.out_ptr, bif.out_port_id); end
        bif.out_ready = 1'b1; tick();
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== 10'd8 || bif.out_port_id !== 4'd9) begin
            n_fail++; $display("FAIL sc_order1 got v%b ptr %0d port %0d want v1 ptr 8 port 9", bif.out_valid, bif.out_ptr, bif.out_port_id); end
    endtask

    task automatic test_collision();
        do_reset();
        bif.init_valid = 1'b1; bif.init_ptr = 10'd60;
        bif.set_valid = 1'b1; bif.set_buf_ptr = 10'd61; bif.set_count = 4'd0;
        set_rel(0, 1, 60); #1;
        n_tests++; if (bif.rel_ready !== 4'b0000) begin n_fail++; $display("FAIL col_ready got %b want 0000", bif.rel_ready); end
        tick(); idle();
        n_tests++; if (bif.err_collision !== 1'b1 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL col_flag got col%b v%b want col1 v0", bif.err_collision, bif.out_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset(); do_init(50); do_set(0, 50, 1); do_set(1, 51, 0);
        rst = 1'b1; set_rel(0, 2, 50); #1;
        n_tests++; if (bif.rel_ready !== 4'b0000 || bif.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mr_in_rst got rdy %b v%b want 0000 v0", bif.rel_ready, bif.out_valid); end
        tick(); tick(); rst = 1'b0; #1;
        n_tests++; if (bif.rel_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_first_ready got %b want 0001", bif.rel_ready); end
        tick(); bif.rel_valid = '0;
        n_tests++; if (bif.out_valid !== 1'b1 || bif.out_ptr !== 10'd50) begin
            n_fail++; $display("FAIL mr_out got v%b ptr %0d want v1 ptr 50", bif.out_valid, bif.out_ptr); end
    endtask

    task automatic test_random();
        int m_rem [16];
        ent_t m_q[$];
        ent_t e;
        int m_rr, occ, g, p, c;
        bit m_eu, m_eo, m_ec;
        int unsigned m_rcnt;
        bit r_init, r_set, r_ordy;
        int r_iptr, r_sport, r_sptr, r_sn;
        logic [NR-1:0] r_rv, exp_v;
        int r_rport [NR];
        int r_rptr [NR];
        do_reset();
        for (int k = 0; k < 16; k++) begin do_init(k); m_rem[k] = 0; end
        m_rr = 0; m_eu = 0; m_eo = 0; m_ec = 0; m_rcnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_init = ($urandom % 20) == 0; r_iptr = $urandom % 16;
            r_set = ($urandom % 3) == 0; r_sport = $urandom % 16; r_sptr = $urandom % 16; r_sn = $urandom % 4;
            r_rv = NR'($urandom); r_ordy = ($urandom % 3) != 0;
            bif.init_valid = r_init; bif.init_ptr = BP'(r_iptr);
            bif.set_valid = r_set; bif.set_port_id = PI'(r_sport); bif.set_buf_ptr = BP'(r_sptr); bif.set_count = RC'(r_sn);
            for (int ch = 0; ch < NR; ch++) begin
                r_rport[ch] = $urandom % 16; r_rptr[ch] = $urandom % 16;
                bif.rel_port_id[ch*PI +: PI] = PI'(r_rport[ch]); bif.rel_ptr[ch*BP +: BP] = BP'(r_rptr[ch]);
            end
            bif.rel_valid = r_rv; bif.out_ready = r_ordy;
            #1;
            occ = m_q.size(); g = -1;
            if (!r_init && (OQ - occ) >= 2)
                for (int k = 0; k < NR; k++) if (g < 0 && r_rv[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            exp_v = '0; if (g >= 0) exp_v[g] = 1'b1;
            n_tests++; if (bif.rel_ready !== exp_v) begin n_fail++; $display("FAIL rnd_grant c%0d got %b want %b", cyc, bif.rel_ready, exp_v); end
            n_tests++; if (bif.out_valid !== (occ > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %0d", cyc, bif.out_valid, occ > 0); end
            if (occ > 0) begin
                n_tests++; if (bif.out_ptr !== BP'(m_q[0].ptr) || bif.out_port_id !== PI'(m_q[0].port)) begin
                    n_fail++; $display("FAIL rnd_head c%0d got ptr %0d port %0d want ptr %0d port %0d", cyc, bif.out_ptr, bif.out_port_id, m_q[0].ptr, m_q[0].port); end
            end
            n_tests++; if (bif.release_cnt !== m_rcnt) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d want %0d", cyc, bif.release_cnt, m_rcnt); end
            n_tests++; if ({bif.err_underflow, bif.err_overflow, bif.err_collision} !== {m_eu, m_eo, m_ec}) begin
                n_fail++; $display("FAIL rnd_errs c%0d got %b want %b", cyc, {bif.err_underflow, bif.err_overflow, bif.err_collision}, {m_eu, m_eo, m_ec}); end
            if (occ > 0 && r_ordy) begin void'(m_q.pop_front()); m_rcnt++; end
            if (r_init) begin
                m_rem[r_iptr] = 0;
                if (r_set) m_ec = 1;
            end else begin
                if (r_set) begin
                    if (r_sn > 0) m_rem[r_sptr] = r_sn;
                    else if (occ < OQ) begin e.port = r_sport; e.ptr = r_sptr; m_q.push_back(e); end
                    else m_eo = 1;
                end
                if (g >= 0) begin
                    p = r_rptr[g];
                    c = (r_set && r_sptr == p) ? r_sn : m_rem[p];
                    if (c > 1) m_rem[p] = c - 1;
                    else if (c == 1) begin m_rem[p] = 0; e.port = r_rport[g]; e.ptr = p; m_q.push_back(e); end
                    else m_eu = 1;
                    m_rr = (g + 1) % NR;
                end
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_count3();
        test_set_zero();
        test_rr();
        test_backpressure();
        test_underflow();
        test_same_cycle();
        test_collision();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bm_buf_release_mc.md
BM_BUF_RELEASE_MC -- requirements
Module: bm_buf_release_mc

Interface
REQ-001 Parameter BUF_PTR_NBITS, default 10, buffer pointer width; counter table depth 2**BUF_PTR_NBITS.
REQ-002 Parameter PORT_ID_NBITS, default 4, port id width.
REQ-003 Parameter READ_COUNT_NBITS, default 4, copy-count width.
REQ-004 Parameter NUM_REL, default 2, number of release-request channels (1..8).
REQ-005 Parameter OQ_DEPTH, default 4, output queue depth (power of 2, >=2).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 init_valid  in  1  clear counter entry init_ptr to 0.
REQ-009 init_ptr  in  BUF_PTR_NBITS  entry to clear.
REQ-010 set_valid  in  1  copy count written for a buffer; no backpressure.
REQ-011 set_port_id / set_buf_ptr / set_count  in  PORT_ID_NBITS / BUF_PTR_NBITS / READ_COUNT_NBITS  port, buffer, number of reads before release.
REQ-012 rel_valid  in  NUM_REL  per-channel release request (one read of buffer done).
REQ-013 rel_port_id / rel_ptr  in  NUM_REL*PORT_ID_NBITS / NUM_REL*BUF_PTR_NBITS  channel i in slice i.
REQ-014 rel_ready  out  NUM_REL  channel i request accepted when rel_valid[i]&rel_ready[i].
REQ-015 out_valid / out_ready  out / in  1 / 1  buffer-free handshake to free list.
REQ-016 out_port_id / out_ptr  out  PORT_ID_NBITS / BUF_PTR_NBITS  freed buffer and its port.
REQ-017 release_cnt  out  32  count of completed out handshakes, wraps at 2**32.
REQ-018 err_underflow / err_overflow / err_collision  out  1 each  sticky error flags.

Function
REQ-019 Counter table holds remaining[ptr], READ_COUNT_NBITS wide; read-modify-write completes in the accept cycle, so same-ptr requests in consecutive cycles see the updated value (no stale reads).
REQ-020 set with set_count=N>0 writes remaining[set_buf_ptr]=N next cycle; set with N=0 pushes {set_port_id,set_buf_ptr} into output queue, table unchanged.
REQ-021 Accepted release on ptr: remaining>1 -> decrement; remaining==1 -> write 0 and push {rel_port_id,ptr} into output queue; remaining==0 -> no write, no push, err_underflow=1.
REQ-022 Port id pushed on release is the releasing channel's rel_port_id.
REQ-023 Arbitration: round-robin over channels with rel_valid; at most one grant per cycle; pointer advances to granted+1 mod NUM_REL after each grant.
REQ-024 rel_ready is combinational grant, and asserts only when output queue free slots >=2, init_valid=0.
REQ-025 Same-cycle set and accepted release on same ptr: set applied first, then release, i.e. result N-1; N==1 pushes release; N==0 pushes set entry then flags err_underflow.
REQ-026 Same-cycle pushes from set (N=0) and release: set entry enqueued first.
REQ-027 init_valid has highest priority; set_valid in same cycle is dropped and err_collision=1; no releases granted that cycle.
REQ-028 set N=0 with output queue full: entry dropped, err_overflow=1.
REQ-029 Output queue: registered FIFO, up to 2 pushes and 1 pop per cycle; out_valid=~empty; pop on out_valid&out_ready; out_* held stable while out_valid&~out_ready.
REQ-030 Latency: push at cycle T -> out_valid at T+1 if queue was empty; pop and push same cycle allowed when full (pop frees slot only next cycle for grant test).
REQ-031 release_cnt increments by 1 per out handshake.

Reset
REQ-032 During rst: out_valid=0, rel_ready=0, release_cnt=0, all err flags=0, queue empty, RR pointer=0; counter table contents not reset (cleared via init_valid).
REQ-033 rst asserted mid-operation discards queued entries and in-flight requests; first request accepted the cycle after rst deasserts.

Verification
REQ-034 init ptr 5; set ptr 5 count 3; three releases ch0 ptr 5 -> exactly one out_ptr=5 after third, release_cnt=1.
REQ-035 set ptr 9 count 0 port 2 -> out_valid next cycle, out_port_id=2, out_ptr=9, table entry 9 unchanged.
REQ-036 rel_valid=all ones for 4 channels, counts 1 each -> grants ch0,ch1,ch2,ch3 in order, one per cycle.
REQ-037 out_ready=0, releases complete until queue has 1 free slot -> rel_ready=0, out_* stable; set count 0 fills last slot; next set count 0 -> err_overflow=1.
REQ-038 Release on ptr with remaining 0 -> no out_valid, err_underflow=1 held until rst.
REQ-039 Same cycle set ptr 7 count 1 and release ptr 7 -> out_ptr=7 next cycle, remaining[7]=0.
